// File: rtl/wave_capture.sv
// Waveform capture: arms on enable, triggers on extTrig or a rising threshold crossing,
// records NSAMPLES consecutive 14-bit samples and freezes them until the reader is done.
module wave_capture #(
  parameter int NSAMPLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] adcData,
  input  logic        enable,
  input  logic        extTrig,
  input  logic        selfTrig,
  input  logic [13:0] threshold,
  input  logic        readoutDone,
  output logic [13:0] waveform [NSAMPLES],
  output logic [15:0] wavenum,
  output logic        acquire,
  output logic        armed,
  output logic        busy
);

  localparam int IDX_W = (NSAMPLES > 1) ? $clog2(NSAMPLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NSAMPLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] index_next;
  logic [IDX_W-1:0] wr_addr;
  logic [13:0]      prev_sample;
  logic [15:0]      capture_count;
  logic             trigger;
  logic             wr_en;
  logic             done;

  // prev_sample tracks every cycle, so a crossing straddling the arming edge still fires
  assign trigger = selfTrig ? ((prev_sample < threshold) && (adcData >= threshold)) : extTrig;

  always_comb begin
    state_next = state;
    index_next = index;
    wr_addr    = index;
    wr_en      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (trigger) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          if (LAST == '0) begin
            state_next = HOLD;
            done       = 1'b1;
            index_next = '0;
          end else begin
            state_next = CAPTURE;
            index_next = IDX_W'(1);
          end
        end
      end
      CAPTURE: begin
        wr_en = 1'b1;
        if (index == LAST) begin
          state_next = HOLD;
          done       = 1'b1;
          index_next = '0;
        end else begin
          index_next = index + IDX_W'(1);
        end
      end
      HOLD: begin
        if (readoutDone) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      index         <= '0;
      prev_sample   <= '0;
      capture_count <= '0;
      acquire       <= 1'b0;
    end else begin
      state       <= state_next;
      index       <= index_next;
      prev_sample <= adcData;
      acquire     <= (state_next == HOLD);
      if (done) capture_count <= capture_count + 16'd1;
    end
  end

  // Sample storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!reset && wr_en) waveform[wr_addr] <= adcData;
  end

  assign wavenum = capture_count;
  assign armed   = (state == ARMED);
  assign busy    = (state == CAPTURE);

endmodule

// File: tb/tb_wave_capture.sv
// Directed sequence with randomized sample data; the expected waveform is simply the
// NSAMPLES values presented starting at the trigger edge, collected in a queue.
module tb_wave_capture;

  localparam int NS = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] adcData;
  logic        enable;
  logic        extTrig;
  logic        selfTrig;
  logic [13:0] threshold;
  logic        readoutDone;
  logic [13:0] waveform [NS];
  logic [15:0] wavenum;
  logic        acquire;
  logic        armed;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  int          model_rec = 0;
  logic [13:0] model_wave [$];
  logic [15:0] model_count = 16'd0;

  always #5 clk = ~clk;

  wave_capture #(.NSAMPLES(NS)) dut (
    .clk(clk),
    .reset(reset),
    .adcData(adcData),
    .enable(enable),
    .extTrig(extTrig),
    .selfTrig(selfTrig),
    .threshold(threshold),
    .readoutDone(readoutDone),
    .waveform(waveform),
    .wavenum(wavenum),
    .acquire(acquire),
    .armed(armed),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; the model records whatever sample the DUT sees on this edge
  task automatic tick();
    if (model_rec > 0) begin
      model_wave.push_back(adcData);
      model_rec--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_model();
    model_wave.delete();
    model_rec = NS;
  endtask

  task automatic check_wave(input string tag);
    for (int k = 0; k < NS; k++)
      check($sformatf("%s_wave[%0d]", tag, k), 32'(waveform[k]),
            (k < model_wave.size()) ? 32'(model_wave[k]) : 32'hFFFF_FFFF);
  endtask

  // Runs the rest of a capture (trigger edge already taken) with random data and triggers
  task automatic finish_capture(input string tag);
    int edges = 1;
    while (!acquire && edges < NS + 20) begin
      adcData = 14'($urandom);
      extTrig = 1'($urandom);
      tick();
      edges++;
    end
    extTrig = 1'b0;
    model_count = model_count + 16'd1;
    check({tag, "_length"}, 32'(edges), 32'(NS));
    check({tag, "_acquire"}, 32'(acquire), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_armed_off"}, 32'(armed), 32'd0);
    check({tag, "_wavenum"}, 32'(wavenum), 32'(model_count));
    check_wave(tag);
  endtask

  task automatic readout(input string tag);
    readoutDone = 1'b1;
    tick();
    readoutDone = 1'b0;
    check({tag, "_acq_low"}, 32'(acquire), 32'd0);
    check({tag, "_idle"}, 32'(armed | busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; extTrig = 1'b0; selfTrig = 1'b0;
    threshold = 14'h2000; readoutDone = 1'b0; adcData = 14'd0;
    tick();
    tick();
    check("reset_armed", 32'(armed), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_acquire", 32'(acquire), 32'd0);
    check("reset_wavenum", 32'(wavenum), 32'd0);
    reset = 1'b0;

    // External trigger on a ramp, pulse at sample 100
    begin
      int edges = 0;
      enable = 1'b1;
      for (int v = 0; v < 1300 && !acquire; v++) begin
        adcData = 14'(v);
        extTrig = (v == 100);
        tick();
        if (v == 0) check("ramp_armed", 32'(armed), 32'd1);
        if (v == 99) check("ramp_still_armed", 32'(armed), 32'd1);
        if (v == 100) check("ramp_busy", 32'(busy), 32'd1);
        if (v >= 100) edges++;
      end
      extTrig = 1'b0;
      model_count = 16'd1;
      check("ramp_length", 32'(edges), 32'(NS));
      check("ramp_acquire", 32'(acquire), 32'd1);
      check("ramp_wavenum", 32'(wavenum), 32'd1);
      for (int k = 0; k < NS; k++)
        check($sformatf("ramp_wave[%0d]", k), 32'(waveform[k]), 32'(100 + k));
    end

    // Hold: triggers and data churn must not disturb the frozen waveform
    for (int i = 0; i < 20; i++) begin
      adcData = 14'($urandom);
      extTrig = 1'(i);
      selfTrig = 1'($urandom);
      threshold = 14'($urandom);
      readoutDone = 1'b0;
      tick();
      check("hold_acquire", 32'(acquire), 32'd1);
    end
    selfTrig = 1'b1; extTrig = 1'b0; threshold = 14'h2000; adcData = 14'h2100;
    for (int k = 0; k < NS; k++)
      check($sformatf("hold_wave[%0d]", k), 32'(waveform[k]), 32'(100 + k));
    check("hold_wavenum", 32'(wavenum), 32'd1);
    readout("hold_readout");
    tick();
    check("rearm_after_readout", 32'(armed), 32'd1);

    // Self trigger: level above threshold without a crossing must not fire
    for (int i = 0; i < 10; i++) begin
      tick();
      check("self_no_cross", 32'(armed), 32'd1);
    end
    adcData = 14'h1FFF;
    tick();
    check("self_below", 32'(armed), 32'd1);
    start_model();
    adcData = 14'h2000;
    tick();
    check("self_fire", 32'(busy), 32'd1);
    finish_capture("self");
    check("self_first", 32'(waveform[0]), 32'h2000);

    // Readout ignored outside HOLD, then crossing straddling the arming edge
    enable = 1'b0;
    readout("self_readout");
    readoutDone = 1'b1;
    tick();
    readoutDone = 1'b0;
    check("idle_readout_ignored", 32'(armed | busy | acquire), 32'd0);
    adcData = 14'h1000; enable = 1'b1;
    tick();
    check("cross_armed", 32'(armed), 32'd1);
    adcData = 14'h3000;
    tick();
    check("cross_fire", 32'(busy), 32'd1);

    // Reset at write index 500
    for (int i = 0; i < 499; i++) begin
      adcData = 14'($urandom);
      tick();
    end
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_count = 16'd0;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_wavenum", 32'(wavenum), 32'd0);
    check("midreset_acquire", 32'(acquire), 32'd0);
    check("midreset_armed", 32'(armed), 32'd0);
    selfTrig = 1'b0;
    tick();
    check("post_reset_armed", 32'(armed), 32'd1);
    start_model();
    adcData = 14'($urandom); extTrig = 1'b1;
    tick();
    extTrig = 1'b0;
    check("post_reset_busy", 32'(busy), 32'd1);
    finish_capture("post_reset");

    // Enable dropped together with a trigger while armed
    readout("post_reset_readout");
    tick();
    check("prio_armed", 32'(armed), 32'd1);
    enable = 1'b0; extTrig = 1'b1;
    tick();
    check("prio_idle", 32'(armed | busy), 32'd0);
    check("prio_wavenum", 32'(wavenum), 32'(model_count));
    tick();
    check("prio_stays_idle", 32'(armed | busy), 32'd0);
    extTrig = 1'b0;

    // Counter wrap; enable also drops mid-capture without aborting
    force dut.capture_count = 16'hFFFF;
    tick();
    release dut.capture_count;
    tick();
    model_count = 16'hFFFF;
    check("wrap_preload", 32'(wavenum), 32'hFFFF);
    enable = 1'b1;
    tick();
    check("wrap_armed", 32'(armed), 32'd1);
    start_model();
    adcData = 14'($urandom); extTrig = 1'b1;
    tick();
    extTrig = 1'b0; enable = 1'b0;
    check("wrap_busy", 32'(busy), 32'd1);
    finish_capture("wrap");
    check("wrap_zero", 32'(wavenum), 32'h0000);
    readout("wrap_readout");
    tick();
    check("no_rearm_when_disabled", 32'(armed), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 Parameter NSAMPLES, default 1000, SHALL set the number of 14-bit samples stored per waveform.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 adcData  input  14  SHALL carry the unsigned ADC sample, valid every clk.
REQ-005 enable  input  1  SHALL permit arming when high.
REQ-006 extTrig  input  1  SHALL be the external trigger, level-sampled.
REQ-007 selfTrig  input  1  SHALL select the threshold trigger (1) or extTrig (0).
REQ-008 threshold  input  14  SHALL set the unsigned self-trigger level.
REQ-009 readoutDone  input  1  SHALL be a one-cycle pulse from the readout side marking the waveform consumed.
REQ-010 waveform  output  14 x NSAMPLES  SHALL be the stored sample array; index 0 holds the first captured sample.
REQ-011 wavenum  output  16  SHALL count completed captures.
REQ-012 acquire  output  1  SHALL be high while a complete, frozen waveform is available for readout.
REQ-013 armed  output  1  SHALL be high in state ARMED.
REQ-014 busy  output  1  SHALL be high in state CAPTURE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ARMED, CAPTURE, HOLD.
REQ-016 IDLE -> ARMED on the edge where enable=1; otherwise remain IDLE.
REQ-017 ARMED -> IDLE on the edge where enable=0, with enable taking priority over a simultaneous trigger.
REQ-018 The trigger SHALL be extTrig=1 when selfTrig=0, and, when selfTrig=1, a rising crossing: previous-cycle adcData < threshold and current adcData >= threshold.
REQ-019 The previous-sample register SHALL update every cycle in all states, so a crossing spanning the IDLE->ARMED edge is detected.
REQ-020 On a trigger edge in ARMED, waveform[0] SHALL take that edge's adcData, the write index SHALL become 1, and the state SHALL go to CAPTURE.
REQ-021 In CAPTURE, each edge SHALL write adcData to waveform[index] and increment index; the capture SHALL span exactly NSAMPLES consecutive edges, with no gaps.
REQ-022 On the edge that writes index NSAMPLES-1, the FSM SHALL enter HOLD, increment wavenum modulo 2^16 (0xFFFF -> 0x0000), and reset index to 0.
REQ-023 acquire SHALL be registered: high from the first cycle in HOLD until readoutDone is sampled.
REQ-024 In HOLD, waveform and wavenum SHALL remain frozen, and triggers SHALL be ignored.
REQ-025 HOLD -> IDLE on the edge where readoutDone=1, and acquire SHALL be 0 the next cycle.
REQ-026 readoutDone in any state other than HOLD SHALL be ignored.
REQ-027 Triggers during CAPTURE SHALL be ignored.
REQ-028 Dropping enable during CAPTURE or HOLD SHALL NOT abort; it only prevents re-arming from IDLE.
REQ-029 armed and busy SHALL be decoded from registered state, and SHALL be mutually exclusive with each other and with acquire.

Reset
REQ-030 reset=1 SHALL force state IDLE, index 0, wavenum 0x0000, acquire 0, armed 0, busy 0, and previous-sample 0, overriding all other inputs, including mid-capture.
REQ-031 waveform contents SHALL NOT be cleared by reset and are undefined until the first completed capture.

Verification
REQ-032 Ext trigger: reset, enable=1, selfTrig=0, adcData = ramp 0,1,2,..., extTrig pulse when adcData=100 -> waveform[k]=100+k for k=0..999, wavenum=1, acquire=1 starting 1000 cycles after the trigger edge.
REQ-033 Self trigger: threshold=0x2000, adcData 0x1FFF then 0x2000 -> waveform[0]=0x2000; adcData held at 0x2100 with no crossing -> no trigger, armed stays 1.
REQ-034 Hold/readout: in HOLD, toggle extTrig and vary adcData -> waveform unchanged; readoutDone pulse -> acquire=0 next cycle, then armed=1 one cycle later if enable=1.
REQ-035 Wrap: preload 65535 captures (or force wavenum=0xFFFF) and complete one capture -> wavenum=0x0000.
REQ-036 Reset mid-capture: assert reset at index 500 -> next cycle busy=0, wavenum=0, acquire=0; the following capture starts at waveform[0].
REQ-037 Enable priority: in ARMED, drive enable=0 and extTrig=1 on the same edge -> state IDLE, busy=0, wavenum unchanged.
